// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-ported word memory between the
// loader/debug port (LD), the MEM-stage data port (DM) and instruction fetch (IF).
//
// Each access runs IDLE/DONE(grant) -> ISSUE -> WAIT -> DONE(ack), so an ack
// arrives 3 cycles after the request is sampled. Priority is LD > DM > IF,
// except that IF beats DM once DM has won STARVE_MAX times in a row while IF
// was waiting. All memory-side outputs and acks are registered.
//
// Ports:
//   clk1, rst                       clock, synchronous active-high reset
//   ld_req/ld_we/ld_addr/ld_wdata   loader request, ld_ack completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data-port request, dm_ack completion pulse
//   if_req/if_addr                  fetch read request, if_ack completion pulse
//   rdata                           read data, valid in the ack cycle
//   busy                            high while an access is in flight
//   mem_addr/mem_we/mem_wdata       registered memory controls
//   mem_rdata                       memory read data, 1-cycle latency
//   perf_clr, perf_*_cnt            perf counters (MIPS32_ARB_PERF_EN only)
//
// Optional feature: define MIPS32_ARB_PERF_EN to add saturating grant and
// stall counters. Arbitration timing is identical either way.

module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS32_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_if_cnt,
    output logic [CNT_W-1:0]  perf_dm_cnt,
    output logic [CNT_W-1:0]  perf_ld_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1 || CNT_W < 2) begin : g_bad_param
        $error("mips32_mem_arbiter: STARVE_MAX must be >=1 and CNT_W >=2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    // one-hot owner of the access in flight: {if, dm, ld}
    logic [2:0]        own;
    logic [SC_W-1:0]   starve_cnt;

    logic [2:0]        excl;
    logic [2:0]        cand;
    logic [2:0]        gnt;
    logic              if_first;
    logic              grant;
    logic [ADDR_W-1:0] g_addr;
    logic              g_we;
    logic [DATA_W-1:0] g_wdata;

    // In DONE the acked port still shows its old req, so it must not win again.
    always_comb begin
        excl     = (state == S_DONE) ? own : 3'b000;
        cand     = {if_req, dm_req, ld_req} & ~excl;
        if_first = (starve_cnt == SC_W'(STARVE_MAX));
        gnt      = 3'b000;
        if (cand[0])
            gnt = 3'b001;
        else if (cand[2] && (if_first || !cand[1]))
            gnt = 3'b100;
        else if (cand[1])
            gnt = 3'b010;
        grant = ((state == S_IDLE) || (state == S_DONE)) && (gnt != 3'b000);
    end

    always_comb begin
        g_addr  = '0;
        g_we    = 1'b0;
        g_wdata = '0;
        unique case (1'b1)
            gnt[0]: begin
                g_addr  = ld_addr;
                g_we    = ld_we;
                g_wdata = ld_wdata;
            end
            gnt[1]: begin
                g_addr  = dm_addr;
                g_we    = dm_we;
                g_wdata = dm_wdata;
            end
            gnt[2]: begin
                g_addr  = if_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= S_IDLE;
            own       <= 3'b000;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            ld_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_ack    <= 1'b0;
        end else begin
            ld_ack <= 1'b0;
            dm_ack <= 1'b0;
            if_ack <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (grant) begin
                        own       <= gnt;
                        mem_addr  <= g_addr;
                        mem_we    <= g_we;
                        mem_wdata <= g_wdata;
                        state     <= S_ISSUE;
                    end else begin
                        own   <= 3'b000;
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mem_we <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    rdata  <= mem_rdata;
                    ld_ack <= own[0];
                    dm_ack <= own[1];
                    if_ack <= own[2];
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counts DM wins while IF keeps waiting; any gap in if_req forgives it.
    always_ff @(posedge clk1) begin
        if (rst)
            starve_cnt <= '0;
        else if (!if_req)
            starve_cnt <= '0;
        else if (grant && gnt[2])
            starve_cnt <= '0;
        else if (grant && gnt[1] && !if_first)
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    assign busy = (state != S_IDLE);

`ifdef MIPS32_ARB_PERF_EN
    logic [2:0] waiting;
    logic [1:0] stall_inc;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [1:0]       b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // IDLE is the arbitration cycle itself, so only busy cycles count as stalls.
    always_comb begin
        waiting   = busy ? ({if_req, dm_req, ld_req} & ~own) : 3'b000;
        stall_inc = {1'b0, waiting[0]} + {1'b0, waiting[1]}
                  + {1'b0, waiting[2]};
    end

    always_ff @(posedge clk1) begin
        if (rst || perf_clr) begin
            perf_ld_cnt    <= '0;
            perf_dm_cnt    <= '0;
            perf_if_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (grant && gnt[0])
                perf_ld_cnt <= sat_add(perf_ld_cnt, 2'd1);
            if (grant && gnt[1])
                perf_dm_cnt <= sat_add(perf_dm_cnt, 2'd1);
            if (grant && gnt[2])
                perf_if_cnt <= sat_add(perf_if_cnt, 2'd1);
            perf_stall_cnt <= sat_add(perf_stall_cnt, stall_inc);
        end
    end
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: behavioural memory, single-access vector
// table, and hand-written multi-port, starvation, early-drop and reset cases.

module tb_mips32_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        ld_req, ld_we, ld_ack;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        dm_req, dm_we, dm_ack;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        if_req, if_ack;
    logic [9:0]  if_addr;
    logic [31:0] rdata;
    logic        busy;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MIPS32_ARB_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_if_cnt, perf_dm_cnt, perf_ld_cnt, perf_stall_cnt;
`endif

    mips32_mem_arbiter dut (
        .clk1(clk1), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MIPS32_ARB_PERF_EN
        , .perf_clr(perf_clr),
        .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt),
        .perf_ld_cnt(perf_ld_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    // behavioural single-port memory, 1-cycle read latency
    logic [31:0] mem [1024];
    logic        mem_init;
    always @(posedge clk1) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[7] <= 32'hfc000000;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int          we_pulses = 0;
    logic [9:0]  last_we_addr = '0;
    always @(negedge clk1) begin
        if (mem_we) begin
            we_pulses    <= we_pulses + 1;
            last_we_addr <= mem_addr;
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]  port;
        bit          rd;
        logic [31:0] data;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int p, input bit rd, input logic [31:0] d,
                        input int lat);
        exp_t e;
        e.port = 3'b001 << p;
        e.rd   = rd;
        e.data = d;
        e.t0   = cyc;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // scoreboard: every ack must match the oldest expected completion
    always @(negedge clk1) begin
        logic [2:0] got;
        exp_t       e;
        got = {if_ack, dm_ack, ld_ack};
        if (got != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(got), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(got), 32'(e.port));
                if (e.rd) chk("rdata", rdata, e.data);
                if (e.lat != 0)
                    chk("ack_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [9:0] a, input logic [31:0] wd);
        case (p)
            0: begin ld_req = r; ld_we = we; ld_addr = a; ld_wdata = wd; end
            1: begin dm_req = r; dm_we = we; dm_addr = a; dm_wdata = wd; end
            default: begin if_req = r; if_addr = a; end
        endcase
    endtask

    function automatic logic ack_of(input int p);
        case (p)
            0: return ld_ack;
            1: return dm_ack;
            default: return if_ack;
        endcase
    endfunction

    task automatic xfer(input int p, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, input logic [31:0] ex);
        int w0;
        bit seen;
        @(negedge clk1);
        w0 = we_pulses;
        set_req(p, 1'b1, we, a, wd);
        push(p, !we, ex, 3);
        seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk1);
            seen = ack_of(p);
        end
        chk("ack_seen", 32'(seen), 32'd1);
        set_req(p, 1'b0, we, a, wd);
        chk("we_pulses", 32'(we_pulses - w0), we ? 32'd1 : 32'd0);
        if (we) begin
            chk("we_addr", 32'(last_we_addr), 32'(a));
            chk("mem_content", mem[a], wd);
        end
    endtask

    typedef struct {
        int          p;
        logic        we;
        logic [9:0]  a;
        logic [31:0] wd;
        logic [31:0] ex;
    } vec_t;
    vec_t vt[9];

    initial begin
        int ord[12];
        logic [31:0] dat[3];
        int n;

        vt[0] = '{0, 1'b1, 10'd120,  32'h00000055, 32'h0};
        vt[1] = '{0, 1'b0, 10'd120,  32'h0,        32'h00000055};
        vt[2] = '{1, 1'b1, 10'd1023, 32'hDEADBEEF, 32'h0};
        vt[3] = '{2, 1'b0, 10'd1023, 32'h0,        32'hDEADBEEF};
        vt[4] = '{1, 1'b0, 10'd7,    32'h0,        32'hfc000000};
        vt[5] = '{0, 1'b1, 10'd0,    32'h12345678, 32'h0};
        vt[6] = '{2, 1'b0, 10'd0,    32'h0,        32'h12345678};
        vt[7] = '{1, 1'b1, 10'd512,  32'hA5A5A5A5, 32'h0};
        vt[8] = '{0, 1'b0, 10'd512,  32'h0,        32'hA5A5A5A5};

        rst = 1'b1; mem_init = 1'b1;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req = 0; if_addr = '0;
`ifdef MIPS32_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk1);
        chk("rst_acks", 32'({ld_ack, dm_ack, if_ack}), 32'd0);
        chk("rst_busy_we", 32'({busy, mem_we}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0; mem_init = 1'b0;
        repeat (2) @(negedge clk1);

        for (int i = 0; i < 9; i++)
            xfer(vt[i].p, vt[i].we, vt[i].a, vt[i].wd, vt[i].ex);

        // all three ports raised together: LD, then DM, then IF
`ifdef MIPS32_ARB_PERF_EN
        @(negedge clk1); perf_clr = 1'b1;
        @(negedge clk1); perf_clr = 1'b0;
`endif
        @(negedge clk1);
        set_req(0, 1'b1, 1'b1, 10'd300, 32'h00000077);
        set_req(1, 1'b1, 1'b0, 10'd120, 32'h0);
        set_req(2, 1'b1, 1'b0, 10'd0,   32'h0);
        push(0, 1'b0, 32'h0, 3);
        push(1, 1'b1, 32'h00000055, 6);
        push(2, 1'b1, 32'h12345678, 9);
        @(negedge clk1);
        chk("busy_in_flight", 32'(busy), 32'd1);
        for (int k = 0; k < 20 && (ld_req || dm_req || if_req); k++) begin
            if (ld_ack) ld_req = 1'b0;
            if (dm_ack) dm_req = 1'b0;
            if (if_ack) if_req = 1'b0;
            if (ld_req || dm_req || if_req) @(negedge clk1);
        end
        chk("multi_all_acked", 32'({ld_req, dm_req, if_req}), 32'd0);
        @(negedge clk1);
        chk("busy_after_multi", 32'(busy), 32'd0);
`ifdef MIPS32_ARB_PERF_EN
        chk("perf_ld_cnt", 32'(perf_ld_cnt), 32'd1);
        chk("perf_dm_cnt", 32'(perf_dm_cnt), 32'd1);
        chk("perf_if_cnt", 32'(perf_if_cnt), 32'd1);
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'd9);
        perf_clr = 1'b1;
        @(negedge clk1);
        perf_clr = 1'b0;
        chk("perf_clr", 32'({perf_ld_cnt, perf_dm_cnt}) |
            32'({perf_if_cnt, perf_stall_cnt}), 32'd0);
`endif

        // early req drop: in-flight access completes from registered inputs
        @(negedge clk1);
        set_req(1, 1'b1, 1'b0, 10'd120, 32'h0);
        push(1, 1'b1, 32'h00000055, 3);
        @(negedge clk1);
        set_req(1, 1'b0, 1'b0, 10'd0, 32'h0);
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            @(negedge clk1);
            if (dm_ack) n = 1;
        end
        chk("early_drop_ack", 32'(n), 32'd1);

        // starvation: LD and DM keep requesting while IF waits
        ord = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
        dat = '{32'h00000055, 32'hfc000000, 32'h12345678};
        repeat (2) @(negedge clk1);
        set_req(0, 1'b1, 1'b0, 10'd120, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'd7,   32'h0);
        set_req(2, 1'b1, 1'b0, 10'd0,   32'h0);
        for (int i = 0; i < 12; i++) push(ord[i], 1'b1, dat[ord[i]], 3 * (i + 1));
        n = 0;
        for (int k = 0; k < 60 && n < 12; k++) begin
            @(negedge clk1);
            if (ld_ack || dm_ack || if_ack) n++;
        end
        ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        chk("starve_ack_count", 32'(n), 32'd12);

        // reset during WAIT of a DM read: dropped, no ack
        repeat (2) @(negedge clk1);
        set_req(1, 1'b1, 1'b0, 10'd300, 32'h0);
        repeat (2) @(negedge clk1);
        rst = 1'b1;
        dm_req = 1'b0;
        @(negedge clk1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ack", 32'(dm_ack), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk1);
        xfer(2, 1'b0, 10'd7, 32'h0, 32'hfc000000);

        repeat (3) @(negedge clk1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
